// File: rtl/cmd_sequencer.sv
// cmd_sequencer: parses UART command bytes, holds the mux config registers and pushes response bytes into the TX FIFO
// Ports:
//   clk, rst_n        - system clock, asynchronous active-low reset
//   rx_valid, rx_data - received byte strobe and data from uart_rx
//   fifo_full         - TX FIFO back-pressure
//   fifo_wr_en/_data  - response byte push into TX FIFO
//   enabled_out       - output-enable mask to mux
//   selectors         - pin-map selectors to mux (2 bits per output)
//   busy              - not IDLE
//   rx_drop           - pulse: byte discarded while responding
//   err_timeout       - pulse: partial write abandoned after payload timeout
// Build option: define CMD_ACK_EN to send a 0xAA ack byte after each committed write.
module cmd_sequencer #(
  parameter int          TIMEOUT_CYCLES = 65535,
  parameter logic [15:0] MASK_RESET     = 16'hAA55,
  parameter logic [31:0] SEL_RESET      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        fifo_full,
  output logic        fifo_wr_en,
  output logic [7:0]  fifo_wr_data,
  output logic [15:0] enabled_out,
  output logic [31:0] selectors,
  output logic        busy,
  output logic        rx_drop,
  output logic        err_timeout
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [1:0] {IDLE, RX_PAYLOAD, TX_RESP} state_t;
  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [31:0]   sh_q, sh_d, sh_in;
  logic          tgt_q, tgt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [15:0]   mask_q, mask_d;
  logic [31:0]   sel_q, sel_d;
  logic          drop_q, drop_d, err_q, err_d;
  // sh_q doubles as the payload assembler (bytes enter at the top, so the
  // newest byte is most significant) and as the response shifter (low byte out).
  assign sh_in        = {rx_data, sh_q[31:8]};
  assign fifo_wr_en   = (state_q == TX_RESP) && !fifo_full;
  assign fifo_wr_data = (state_q == TX_RESP) ? sh_q[7:0] : 8'h00;
  assign enabled_out  = mask_q;
  assign selectors    = sel_q;
  assign busy         = state_q != IDLE;
  assign rx_drop      = drop_q;
  assign err_timeout  = err_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    tgt_d   = tgt_q;
    tmo_d   = tmo_q;
    mask_d  = mask_q;
    sel_d   = sel_q;
    drop_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_valid && (rx_data == 8'h01 || rx_data == 8'h02)) begin
          state_d = TX_RESP;
          cnt_d   = (rx_data == 8'h01) ? 3'd2 : 3'd4;
          sh_d    = (rx_data == 8'h01) ? {16'h0000, mask_q} : sel_q;
        end else if (rx_valid && (rx_data == 8'h03 || rx_data == 8'h04)) begin
          state_d = RX_PAYLOAD;
          cnt_d   = (rx_data == 8'h03) ? 3'd2 : 3'd4;
          sh_d    = '0;
          tgt_d   = rx_data == 8'h04;
          tmo_d   = '0;
        end
      end
      RX_PAYLOAD: begin
        if (rx_valid) begin
          sh_d  = sh_in;
          cnt_d = cnt_q - 3'd1;
          tmo_d = '0;
          if (cnt_q == 3'd1) begin
            // a 2-byte mask payload ends up in the top half of the assembler
            if (tgt_q) sel_d = sh_in;
            else mask_d = sh_in[31:16];
`ifdef CMD_ACK_EN
            state_d = TX_RESP;
            cnt_d   = 3'd1;
            sh_d    = 32'h0000_00AA;
`else
            state_d = IDLE;
`endif
          end
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      TX_RESP: begin
        drop_d = rx_valid;
        if (fifo_wr_en) begin
          sh_d  = {8'h00, sh_q[31:8]};
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      tgt_q   <= 1'b0;
      tmo_q   <= '0;
      mask_q  <= MASK_RESET;
      sel_q   <= SEL_RESET;
      drop_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      tgt_q   <= tgt_d;
      tmo_q   <= tmo_d;
      mask_q  <= mask_d;
      sel_q   <= sel_d;
      drop_q  <= drop_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_cmd_sequencer.sv
// tb_cmd_sequencer: randomized and directed check of cmd_sequencer against a command-level model
module tb_cmd_sequencer;
  localparam int TO = 40;
  logic        clk = 0, rst_n = 0, rx_valid = 0, fifo_full = 0;
  logic [7:0]  rx_data = 0;
  logic        fifo_wr_en, busy, rx_drop, err_timeout;
  logic [7:0]  fifo_wr_data;
  logic [15:0] enabled_out;
  logic [31:0] selectors;
  int          checks = 0, errors = 0, drop_cnt = 0;
  bit          rnd_full = 0;
  logic [7:0]  rx_q[$], ex_q[$];
  logic [15:0] m_mask = 16'hAA55;
  logic [31:0] m_map = 32'h0;

  cmd_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .enabled_out(enabled_out), .selectors(selectors), .busy(busy),
    .rx_drop(rx_drop), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n) begin
    if (fifo_wr_en) rx_q.push_back(fifo_wr_data);
    if (rx_drop) drop_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_full) fifo_full = ($urandom_range(0, 2) == 0);
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1;
    tick();
    rx_valid = 0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && busy; i++) tick();
    chk("idle_wait", busy, 0);
  endtask

  task automatic check_resp();
    chk("resp_len", rx_q.size(), ex_q.size());
    for (int i = 0; i < rx_q.size() && i < ex_q.size(); i++) chk("resp_byte", rx_q[i], ex_q[i]);
    rx_q.delete();
    ex_q.delete();
  endtask

  // Command-level reference: reads emit the register little-endian, writes replace it.
  task automatic model(input logic [7:0] op, input logic [31:0] pl);
    if (op == 8'h01) begin
      ex_q.push_back(m_mask[7:0]);
      ex_q.push_back(m_mask[15:8]);
    end else if (op == 8'h02) begin
      for (int i = 0; i < 4; i++) ex_q.push_back(m_map[8*i +: 8]);
    end else if (op == 8'h03 || op == 8'h04) begin
      if (op == 8'h03) m_mask = pl[15:0];
      else m_map = pl;
`ifdef CMD_ACK_EN
      ex_q.push_back(8'hAA);
`endif
    end
  endtask

  task automatic run_cmd(input logic [7:0] op, input logic [31:0] pl, input bit gaps);
    int n;
    n = (op == 8'h03) ? 2 : (op == 8'h04) ? 4 : 0;
    send(op);
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) tick();
      send(pl[8*i +: 8]);
    end
    model(op, pl);
    wait_idle();
    check_resp();
    chk("mask", enabled_out, m_mask);
    chk("sel", selectors, m_map);
  endtask

  initial begin
    logic [7:0] op;
    int d0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mask", enabled_out, 16'hAA55);
    chk("rst_sel", selectors, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr_en", fifo_wr_en, 0);
    chk("rst_wr_data", fifo_wr_data, 0);
    chk("rst_flags", {rx_drop, err_timeout}, 0);
    rst_n = 1;
    tick();
    // read mask right after reset: one byte per cycle starting the cycle after decode
    send(8'h01);
    model(8'h01, 0);
    @(negedge clk);
    chk("rd_b0_en", fifo_wr_en, 1);
    chk("rd_b0", fifo_wr_data, 8'h55);
    @(negedge clk);
    chk("rd_b1_en", fifo_wr_en, 1);
    chk("rd_b1", fifo_wr_data, 8'hAA);
    @(negedge clk);
    chk("rd_done", busy, 0);
    tick();
    check_resp();
    // write mask: no partial update, commit visible right after the last byte
    send(8'h03);
    send(8'h34);
    chk("no_partial", enabled_out, 16'hAA55);
    send(8'h12);
    chk("commit", enabled_out, 16'h1234);
    model(8'h03, 32'h1234);
    wait_idle();
    check_resp();
    run_cmd(8'h01, 0, 0);
    // pin map write then a read stalled mid-response
    run_cmd(8'h04, 32'hDEADBEEF, 0);
    send(8'h02);
    model(8'h02, 0);
    tick();
    tick();
    fifo_full = 1;
    repeat (5) begin
      @(negedge clk);
      chk("stall_en", fifo_wr_en, 0);
      chk("stall_data", fifo_wr_data, 8'hAD);
      tick();
    end
    fifo_full = 0;
    wait_idle();
    check_resp();
    // payload timeout: single pulse exactly TO cycles after the last byte
    send(8'h03);
    send(8'h11);
    for (int i = 0; i <= TO + 1; i++) begin
      @(negedge clk);
      chk("err_timeout", err_timeout, i == TO);
    end
    tick();
    chk("tmo_mask", enabled_out, m_mask);
    chk("tmo_idle", busy, 0);
    run_cmd(8'h01, 0, 0);
    // unknown opcode ignored, bytes during a response dropped
    send(8'h07);
    chk("bad_op_idle", busy, 0);
    run_cmd(8'h01, 0, 0);
    d0 = drop_cnt;
    send(8'h01);
    model(8'h01, 0);
    send(8'h01);
    send(8'h02);
    wait_idle();
    tick();
    chk("rx_drop", drop_cnt - d0, 2);
    check_resp();
    // reset mid-payload
    send(8'h04);
    send(8'hAA);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_mask", enabled_out, 16'hAA55);
    chk("mid_rst_sel", selectors, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_wr", {fifo_wr_en, fifo_wr_data}, 0);
    @(negedge clk);
    rst_n = 1;
    tick();
    m_mask = 16'hAA55;
    m_map = 0;
    rx_q.delete();
    ex_q.delete();
    run_cmd(8'h02, 0, 0);
    // randomized command stream with random back-pressure and payload gaps
    rnd_full = 1;
    repeat (60) begin
      case ($urandom_range(0, 4))
        0: op = 8'h01;
        1: op = 8'h02;
        2: op = 8'h03;
        3: op = 8'h04;
        default: op = 8'($urandom_range(5, 255));
      endcase
      run_cmd(op, $urandom, 1);
    end
    rnd_full = 0;
    fifo_full = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
